l2_cache_setassoc: RTL and testbench
====================================

Name: l2_cache_setassoc

Overview:
Parametrised successor to the single-set L2 cache. It is an N-way, M-set, write-back, write-allocate block cache between the L1 block interface and the memory block interface. It adds multiple sets, true-LRU replacement, dirty tracking with victim writeback, and a full-block write-miss path that needs no fill. All transfers are whole blocks. Addresses are block addresses.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 11, block address width
BLOCK_WORDS, 8, words per block
NUM_WAYS, 4, associativity (power of 2, >=2)
NUM_SETS, 16, sets (power of 2); index = addr[log2(NUM_SETS)-1:0], tag = remaining upper bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
l1_cache_addr  in  ADDR_WIDTH  request block address
l1_cache_data_in  in  BLOCK_WORDS*DATA_WIDTH  write block; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
l1_cache_read  in  1  read request
l1_cache_write  in  1  write request
l1_cache_ready  out  1  idle, can accept a request
l1_block_valid  out  1  one-cycle response strobe
l1_cache_hit  out  1  response was a hit; qualified by l1_block_valid
l1_block_data_out  out  BLOCK_WORDS*DATA_WIDTH  read data; qualified by l1_block_valid on reads
mem_addr  out  ADDR_WIDTH  memory block address
mem_data_out  out  BLOCK_WORDS*DATA_WIDTH  writeback block
mem_read  out  1  fill request
mem_write  out  1  writeback request
mem_data_block  in  BLOCK_WORDS*DATA_WIDTH  fill data, valid with mem_ready
mem_ready  in  1  completes the current mem_read or mem_write

Behaviour:
- Reset values: all arrays invalid and clean; LRU age of way w = w; state IDLE; l1_cache_ready=0 while rst=1; all other outputs 0. Reset mid-operation aborts the transaction immediately and drops mem_read/mem_write asynchronously.
- States: IDLE, LOOKUP, WRITEBACK, FILL, RESP.
- IDLE: l1_cache_ready=1. On a clk edge with read or write high, latch addr, data and op, then go to LOOKUP. If both read and write are high, the request is a write. Requests while ready=0 are ignored. mem_ready is ignored outside WRITEBACK and FILL.
- LOOKUP (1 cycle): parallel tag compare on valid ways.
  - Read hit: go to RESP.
  - Write hit: overwrite the block, set dirty, go to RESP.
  - Miss: victim = lowest-index invalid way, otherwise the way with age NUM_WAYS-1. If the victim is valid and dirty, go to WRITEBACK. Otherwise a read goes to FILL and a write goes to RESP, installing the block with dirty=1.
- WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_data_out=victim block, all held stable until mem_ready is sampled high. Then a read goes to FILL; a write installs the block (dirty=1) and goes to RESP.
- FILL: mem_read=1, mem_addr=request addr, held until mem_ready is sampled high. On that edge, install mem_data_block (valid, clean) and go to RESP.
- RESP (1 cycle): l1_block_valid=1, l1_cache_hit=hit flag. For reads, l1_block_data_out = block. Then go to IDLE.
- Latency: a hit gives l1_block_valid in the 2nd cycle after the accept edge and ready again in the 3rd. Each miss adds 1 cycle per memory phase plus memory wait.
- LRU: on hit or install, the accessed way's age becomes 0 and ways whose age is below its old age increment by 1. Ages always form a permutation of 0..NUM_WAYS-1.
- mem_read and mem_write are never high together. Both deassert in the cycle after mem_ready.

Optional Feature:
L2_CACHE_STATS_EN
- Defined: adds output ports stat_hits, stat_misses and stat_writebacks, each 32 bits. They are saturating counters that increment in LOOKUP (hit or miss) and on writeback completion, and clear on rst.
- Undefined: the ports and the logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- Read miss 0x00A; memory returns word i = 0xDEADBEEF^i after 3 cycles. Required: mem_read=1 with mem_addr=0x00A, mem_write stays 0, single l1_block_valid with hit=0, word0=0xDEADBEEF.
- Read 0x00A again. Required: l1_block_valid 2 cycles after accept, hit=1, mem_read stays 0, word3=0xDEADBEEC.
- Write miss 0x014 with data 0xA5A5A5A5^i. Required: no mem_read, no mem_write, hit=0. A following read of 0x014 gives hit=1 and word1=0xA5A5A5A4.
- Write 0x010, 0x020, 0x030, 0x040 (set 0), then write 0x050. Required: mem_write with mem_addr=0x010 and mem_data_out equal to the 0x010 data, and no mem_read. A later read of 0x010 misses with mem_read at mem_addr=0x010.
- Same fill of set 0, then read 0x010 (hit), then write 0x050. Required: evicted mem_addr=0x020.
- Assert rst while mem_read=1 during a 0x00A miss. Required: mem_read drops immediately; after release ready=1; read 0x00A misses again.

Source files
------------

// File: rtl/l2_cache_setassoc_if.sv
// L1-side and memory-side block bus of the set-associative L2 cache.
// slave is the cache's view, master is the requester/memory environment's view.
interface l2_cache_setassoc_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int BLOCK_WORDS = 8
);
  localparam int BLK_W = DATA_WIDTH * BLOCK_WORDS;

  logic [ADDR_WIDTH-1:0] l1_cache_addr;
  logic [BLK_W-1:0]      l1_cache_data_in;
  logic                  l1_cache_read;
  logic                  l1_cache_write;
  logic                  l1_cache_ready;
  logic                  l1_block_valid;
  logic                  l1_cache_hit;
  logic [BLK_W-1:0]      l1_block_data_out;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BLK_W-1:0]      mem_data_out;
  logic                  mem_read;
  logic                  mem_write;
  logic [BLK_W-1:0]      mem_data_block;
  logic                  mem_ready;

  modport slave (
    input  l1_cache_addr, l1_cache_data_in, l1_cache_read, l1_cache_write,
           mem_data_block, mem_ready,
    output l1_cache_ready, l1_block_valid, l1_cache_hit, l1_block_data_out,
           mem_addr, mem_data_out, mem_read, mem_write
  );

  modport master (
    output l1_cache_addr, l1_cache_data_in, l1_cache_read, l1_cache_write,
           mem_data_block, mem_ready,
    input  l1_cache_ready, l1_block_valid, l1_cache_hit, l1_block_data_out,
           mem_addr, mem_data_out, mem_read, mem_write
  );
endinterface

// File: rtl/l2_cache_setassoc.sv
// N-way, M-set write-back/write-allocate block cache with true-LRU and victim writeback.
// Define L2_CACHE_STATS_EN to add saturating hit/miss/writeback counters.
module l2_cache_setassoc #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int BLOCK_WORDS = 8,
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 16
) (
  input  logic clk,
  input  logic rst,
  l2_cache_setassoc_if.slave bus
`ifdef L2_CACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_writebacks
`endif
);
  localparam int BLK_W = DATA_WIDTH * BLOCK_WORDS;
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BLK_W-1:0]      req_data;
  logic                  req_wr;
  logic                  hit_q;
  logic [WAY_W-1:0]      way_q;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid, dirty;
  logic [WAY_W-1:0] age      [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_arr  [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0] data_arr [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign idx = req_addr[IDX_W-1:0];
  assign tag = req_addr[ADDR_WIDTH-1:IDX_W];

  logic [NUM_WAYS-1:0] hit_vec;
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_cmp
    assign hit_vec[w] = valid[idx][w] && (tag_arr[idx][w] == tag);
  end

  // Victim: lowest-index invalid way wins over the oldest way.
  logic             hit, vic_dirty;
  logic [WAY_W-1:0] hit_way, vic_way;
  always_comb begin
    hit_way = '0;
    vic_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (age[idx][w] == WAY_W'(NUM_WAYS - 1)) vic_way = WAY_W'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid[idx][w]) vic_way = WAY_W'(w);
  end
  assign hit       = |hit_vec;
  assign vic_dirty = valid[idx][vic_way] && dirty[idx][vic_way];

  // Single array write port shared by write-hit, write-install and fill.
  logic             wr_en, wr_dirty, touch_en;
  logic [WAY_W-1:0] wr_way, touch_way;
  logic [BLK_W-1:0] wr_data;
  always_comb begin
    wr_en     = 1'b0;
    wr_dirty  = 1'b1;
    wr_way    = way_q;
    wr_data   = req_data;
    touch_en  = 1'b0;
    touch_way = way_q;
    case (state)
      S_LOOKUP:
        if (hit) begin
          touch_en  = 1'b1;
          touch_way = hit_way;
          wr_en     = req_wr;
          wr_way    = hit_way;
        end else if (req_wr && !vic_dirty) begin
          wr_en     = 1'b1;
          wr_way    = vic_way;
          touch_en  = 1'b1;
          touch_way = vic_way;
        end
      S_WB:
        if (bus.mem_ready && req_wr) begin
          wr_en    = 1'b1;
          touch_en = 1'b1;
        end
      S_FILL:
        if (bus.mem_ready) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          wr_data  = bus.mem_data_block;
          touch_en = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      req_addr <= '0;
      req_data <= '0;
      req_wr   <= 1'b0;
      hit_q    <= 1'b0;
      way_q    <= '0;
      valid    <= '0;
      dirty    <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else begin
      if (wr_en) begin
        valid[idx][wr_way] <= 1'b1;
        dirty[idx][wr_way] <= wr_dirty;
      end
      if (touch_en)
        for (int w = 0; w < NUM_WAYS; w++)
          if (WAY_W'(w) == touch_way)              age[idx][w] <= '0;
          else if (age[idx][w] < age[idx][touch_way]) age[idx][w] <= age[idx][w] + WAY_W'(1);
      case (state)
        S_IDLE:
          if (bus.l1_cache_read || bus.l1_cache_write) begin
            req_addr <= bus.l1_cache_addr;
            req_data <= bus.l1_cache_data_in;
            req_wr   <= bus.l1_cache_write;
            state    <= S_LOOKUP;
          end
        S_LOOKUP: begin
          hit_q <= hit;
          way_q <= hit ? hit_way : vic_way;
          if (hit || (req_wr && !vic_dirty)) state <= S_RESP;
          else if (vic_dirty)                state <= S_WB;
          else                               state <= S_FILL;
        end
        S_WB:    if (bus.mem_ready) state <= req_wr ? S_RESP : S_FILL;
        S_FILL:  if (bus.mem_ready) state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tags and data need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_arr[idx][wr_way] <= wr_data;
      tag_arr[idx][wr_way]  <= tag;
    end
  end

  assign bus.l1_cache_ready    = (state == S_IDLE) && !rst;
  assign bus.l1_block_valid    = (state == S_RESP);
  assign bus.l1_cache_hit      = (state == S_RESP) && hit_q;
  assign bus.l1_block_data_out = (state == S_RESP && !req_wr) ? data_arr[idx][way_q] : '0;
  assign bus.mem_write         = (state == S_WB);
  assign bus.mem_read          = (state == S_FILL);
  assign bus.mem_addr          = (state == S_WB)   ? {tag_arr[idx][way_q], idx} :
                                 (state == S_FILL) ? req_addr : '0;
  assign bus.mem_data_out      = (state == S_WB)   ? data_arr[idx][way_q] : '0;

`ifdef L2_CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state == S_LOOKUP && hit && stat_hits != '1)    stat_hits   <= stat_hits + 32'd1;
      if (state == S_LOOKUP && !hit && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      if (state == S_WB && bus.mem_ready && stat_writebacks != '1)
        stat_writebacks <= stat_writebacks + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l2_cache_setassoc.sv
// Scoreboard bench for l2_cache_setassoc: recency-list reference model, randomized traffic.
`timescale 1ns/1ps
module tb_l2_cache_setassoc;
  localparam int DW = 32, AW = 11, BWD = 8, NW = 4, NS = 16, IW = 4, TW = AW - IW;
  localparam int BW = DW * BWD;
  typedef logic [BW-1:0] blk_t;
  typedef struct { bit hit; bit wr; blk_t data; int lat; } resp_t;
  typedef struct { bit wr; logic [AW-1:0] addr; blk_t data; } memop_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  l2_cache_setassoc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BWD)) bus ();
`ifdef L2_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

  l2_cache_setassoc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BWD),
                      .NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef L2_CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, accept_cyc = 0;
  int mem_lat = 3, mem_cnt = -1, mem_ops = 0;
  bit hold_mem = 1'b0;
  resp_t  resp_q[$];
  memop_t mem_q[$];
  blk_t   mem_img [int];
  logic [AW-1:0] last_wb_addr, last_rd_addr;
  blk_t last_data;
  bit   last_hit;

  // Reference model: per-way contents plus a recency list per set (MRU first).
  bit            m_valid [NS][NW];
  bit            m_dirty [NS][NW];
  logic [TW-1:0] m_tag   [NS][NW];
  blk_t          m_data  [NS][NW];
  int            ord     [NS][NW];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic blk_t mem_rd(input logic [AW-1:0] a);
    blk_t b;
    if (mem_img.exists(int'(a))) return mem_img[int'(a)];
    for (int i = 0; i < BWD; i++) b[i*DW +: DW] = 32'h1234_0000 ^ (32'(a) << 8) ^ 32'(i);
    return b;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        ord[s][w] = w;
      end
  endfunction

  function automatic void touch(input int s, input int w);
    int k = 0;
    for (int i = 0; i < NW; i++) if (ord[s][i] == w) k = i;
    for (int i = k; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = w;
  endfunction

  task automatic model_access(input logic [AW-1:0] a, input bit wr, input blk_t d);
    int s, hw, v;
    logic [TW-1:0] t;
    resp_t r;
    memop_t m;
    s = int'(a[IW-1:0]);
    t = a[AW-1:IW];
    hw = -1;
    for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    r.wr = wr; r.hit = (hw >= 0); r.lat = -1;
    if (hw >= 0) begin
      if (wr) begin m_data[s][hw] = d; m_dirty[s][hw] = 1'b1; end
      r.data = m_data[s][hw];
      r.lat = 2;
      touch(s, hw);
    end else begin
      v = -1;
      for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) v = ord[s][NW-1];
      if (m_valid[s][v] && m_dirty[s][v]) begin
        m.wr = 1'b1; m.addr = {m_tag[s][v], IW'(s)}; m.data = m_data[s][v];
        mem_q.push_back(m);
        mem_img[int'(m.addr)] = m.data;
      end else if (wr) r.lat = 2;
      if (wr) begin
        m_data[s][v] = d; m_dirty[s][v] = 1'b1;
      end else begin
        m.wr = 1'b0; m.addr = a; m.data = mem_rd(a);
        mem_q.push_back(m);
        m_data[s][v] = m.data; m_dirty[s][v] = 1'b0;
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v] = t;
      r.data = m_data[s][v];
      touch(s, v);
    end
    resp_q.push_back(r);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (bus.mem_read && bus.mem_write) chk("mem_rd_wr_exclusive", 1, 0);
      if (bus.l1_block_valid) begin
        last_hit = bus.l1_cache_hit;
        last_data = bus.l1_block_data_out;
        if (resp_q.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          r = resp_q.pop_front();
          chk("resp_hit", bus.l1_cache_hit, r.hit);
          if (!r.wr) chk("resp_data", bus.l1_block_data_out, r.data);
          if (r.lat > 0) chk("resp_latency", cyc - accept_cyc + 1, r.lat);
        end
      end
    end
  end

  // Memory responder: checks each operation against the model's queue
  initial begin
    memop_t m;
    bus.mem_ready = 1'b0;
    bus.mem_data_block = '0;
    forever begin
      @(negedge clk);
      if (rst || hold_mem) begin
        bus.mem_ready = 1'b0;
        mem_cnt = -1;
      end else if (bus.mem_ready) bus.mem_ready = 1'b0;
      else if (bus.mem_read || bus.mem_write) begin
        if (mem_cnt < 0) mem_cnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        if (mem_cnt == 0) begin
          mem_cnt = -1;
          mem_ops++;
          bus.mem_ready = 1'b1;
          if (mem_q.size() == 0) chk("unexpected_mem_op", 1, 0);
          else begin
            m = mem_q.pop_front();
            chk("mem_op_is_write", bus.mem_write, m.wr);
            chk("mem_addr", bus.mem_addr, m.addr);
            if (m.wr) begin
              chk("mem_wb_data", bus.mem_data_out, m.data);
              last_wb_addr = bus.mem_addr;
            end else begin
              bus.mem_data_block = mem_rd(m.addr);
              last_rd_addr = bus.mem_addr;
            end
          end
        end else mem_cnt--;
      end
    end
  end

  task automatic do_req(input logic [AW-1:0] a, input bit wr, input blk_t d);
    int n = 0;
    @(negedge clk);
    while (!bus.l1_cache_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.l1_cache_ready) begin chk("ready_timeout", 0, 1); return; end
    model_access(a, wr, d);
    bus.l1_cache_addr = a;
    bus.l1_cache_data_in = d;
    bus.l1_cache_write = wr;
    bus.l1_cache_read = !wr || ($urandom_range(0, 3) == 0);
    @(negedge clk);
    accept_cyc = cyc;
    bus.l1_cache_read = 1'b0;
    bus.l1_cache_write = 1'b0;
    if ($urandom_range(0, 2) == 0) begin
      bus.l1_cache_read = 1'b1;
      bus.l1_cache_addr = AW'($urandom);
      @(negedge clk);
      bus.l1_cache_read = 1'b0;
    end
    n = 0;
    while (resp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (resp_q.size() != 0) begin chk("resp_timeout", 0, 1); resp_q.delete(); end
    chk("mem_ops_consumed", mem_q.size(), 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.l1_cache_read = 1'b0;
    bus.l1_cache_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.l1_cache_ready, 0);
    chk("rst_valid", bus.l1_block_valid, 0);
    chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 0);
    rst = 1'b0;
    model_reset();
    resp_q.delete();
    mem_q.delete();
    @(negedge clk);
    chk("ready_after_rst", bus.l1_cache_ready, 1);
  endtask

  function automatic blk_t pat(input logic [31:0] base);
    blk_t b;
    for (int i = 0; i < BWD; i++) b[i*DW +: DW] = base ^ 32'(i);
    return b;
  endfunction

  function automatic blk_t rnd_blk();
    blk_t b;
    for (int i = 0; i < BWD; i++) b[i*DW +: DW] = $urandom;
    return b;
  endfunction

  initial begin
    int n0, n;
    bus.l1_cache_addr = '0;
    bus.l1_cache_data_in = '0;
    bus.l1_cache_read = 1'b0;
    bus.l1_cache_write = 1'b0;
    mem_img[32'h00A] = pat(32'hDEADBEEF);
    last_wb_addr = '1;
    last_rd_addr = '1;
    reset_dut();

    // read miss then hit on 0x00A
    do_req(11'h00A, 1'b0, '0);
    chk("t1_fill_addr", last_rd_addr, 11'h00A);
    chk("t1_hit", last_hit, 0);
    chk("t1_word0", last_data[31:0], 32'hDEADBEEF);
    n0 = mem_ops;
    do_req(11'h00A, 1'b0, '0);
    chk("t2_hit", last_hit, 1);
    chk("t2_no_mem", mem_ops - n0, 0);
    chk("t2_word3", last_data[3*DW +: DW], 32'hDEADBEEC);

    // write miss into empty way needs no memory traffic
    n0 = mem_ops;
    do_req(11'h014, 1'b1, pat(32'hA5A5A5A5));
    chk("t3_no_mem", mem_ops - n0, 0);
    chk("t3_hit", last_hit, 0);
    do_req(11'h014, 1'b0, '0);
    chk("t3_rd_hit", last_hit, 1);
    chk("t3_word1", last_data[DW +: DW], 32'hA5A5A5A4);

    // fill set 0 with dirty lines, then evict
    for (int i = 1; i <= 4; i++) do_req(AW'(i * 16), 1'b1, pat(32'h0100_0000 * i));
    n0 = mem_ops;
    do_req(11'h050, 1'b1, pat(32'h0500_0000));
    chk("t4_evict_addr", last_wb_addr, 11'h010);
    chk("t4_mem_ops", mem_ops - n0, 1);
    n0 = mem_ops;
    do_req(11'h010, 1'b0, '0);
    chk("t4_refill_addr", last_rd_addr, 11'h010);
    chk("t4_refill_ops", mem_ops - n0, 2);
    chk("t4_refill_hit", last_hit, 0);

    // a hit refreshes recency and shifts the victim
    reset_dut();
    for (int i = 1; i <= 4; i++) do_req(AW'(i * 16), 1'b1, pat(32'h0200_0000 * i));
    do_req(11'h010, 1'b0, '0);
    chk("t5_hit", last_hit, 1);
    do_req(11'h050, 1'b1, pat(32'h0700_0000));
    chk("t5_evict_addr", last_wb_addr, 11'h020);

    // reset in the middle of a fill
    reset_dut();
    hold_mem = 1'b1;
    @(negedge clk);
    bus.l1_cache_addr = 11'h00A;
    bus.l1_cache_read = 1'b1;
    @(negedge clk);
    bus.l1_cache_read = 1'b0;
    n = 0;
    while (!bus.mem_read && n < 20) begin @(negedge clk); n++; end
    chk("t6_mem_read_up", bus.mem_read, 1);
    #2 rst = 1'b1;
    #1 chk("t6_mem_read_drop", bus.mem_read, 0);
    chk("t6_ready_in_rst", bus.l1_cache_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_mem = 1'b0;
    model_reset();
    resp_q.delete();
    mem_q.delete();
    @(negedge clk);
    chk("t6_ready_after", bus.l1_cache_ready, 1);
    do_req(11'h00A, 1'b0, '0);
    chk("t6_miss_again", last_hit, 0);
    chk("t6_word0", last_data[31:0], 32'hDEADBEEF);

    // randomized traffic concentrated on a few sets
    mem_lat = -1;
    for (int k = 0; k < 400; k++)
      do_req({TW'($urandom_range(0, 6)), IW'($urandom_range(0, 3))}, $urandom_range(0, 1) == 1, rnd_blk());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
